// File: rtl/fifo_sync_flags.sv
// rtl/fifo_sync_flags.sv - single-clock FIFO with level flags, occupancy count and sticky errors
// Optional feature macro: FIFO_FWFT_EN selects first-word fall-through read data.
module fifo_sync_flags #(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         w_en,
    input  logic                         r_en,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    // Reject illegal configurations at elaboration time.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "fifo_sync_flags: DEPTH must be a power of 2 and at least 2");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $fatal(1, "fifo_sync_flags: AF_LEVEL out of range 1..DEPTH");
    end
    if ((AE_LEVEL < 0) || (AE_LEVEL > DEPTH - 1)) begin : g_bad_ae
        $fatal(1, "fifo_sync_flags: AE_LEVEL out of range 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic w_rd_ok;
    logic w_wr_ok;
    logic w_ovf_set;
    logic w_unf_set;

    // Flags are pure decodes of the occupancy register.
    assign full         = (r_count == CW'(DEPTH));
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= CW'(AF_LEVEL));
    assign almost_empty = (r_count <= CW'(AE_LEVEL));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A write into a full FIFO only succeeds when the same cycle frees a slot.
    assign w_rd_ok   = r_en && !empty;
    assign w_wr_ok   = w_en && (!full || w_rd_ok);
    assign w_ovf_set = w_en && full && !w_rd_ok;
    assign w_unf_set = r_en && empty;

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr_ok && !w_rd_ok)
                r_count <= r_count + CW'(1);
            else if (w_rd_ok && !w_wr_ok)
                r_count <= r_count - CW'(1);
        end
    end

    // Storage array; contents survive reset, but reset blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) r_mem[r_wr_ptr] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    // Head of queue is always presented; meaningless while empty.
    assign data_out = r_mem[r_rd_ptr];
`else
    logic [DATA_WIDTH-1:0] r_data_out;

    // Registered read: one cycle latency, holds value when no read is accepted.
    always_ff @(posedge clk) begin
        if (rst)
            r_data_out <= '0;
        else if (w_rd_ok)
            r_data_out <= r_mem[r_rd_ptr];
    end

    assign data_out = r_data_out;
`endif

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set)    r_overflow <= 1'b1;
            else if (clr_err) r_overflow <= 1'b0;
            if (w_unf_set)    r_underflow <= 1'b1;
            else if (clr_err) r_underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_sync_flags.sv
// tb/tb_fifo_sync_flags.sv - queue-model bench for fifo_sync_flags with directed and random traffic
module tb_fifo_sync_flags;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int AF    = 6;
    localparam int AE    = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          w_en;
    logic          r_en;
    logic          clr_err;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;

    always #5 clk = ~clk;

    fifo_sync_flags #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .data_in(data_in),
        .data_out(data_out), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow),
        .clr_err(clr_err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_ovf  = 1'b0;
    bit            m_unf  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit w, input bit r, input logic [DW-1:0] d,
                                input bit c, input bit rs);
        bit is_full, is_empty, rd_ok, wr_ok, ovf_set, unf_set;
        if (rs) begin
            q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
        end else begin
            is_full  = (q.size() == DEPTH);
            is_empty = (q.size() == 0);
            rd_ok    = r && !is_empty;
            wr_ok    = w && (!is_full || rd_ok);
            ovf_set  = w && is_full && !rd_ok;
            unf_set  = r && is_empty;
            if (rd_ok) m_dout = q.pop_front();
            if (wr_ok) q.push_back(d);
            m_ovf = ovf_set ? 1'b1 : (c ? 1'b0 : m_ovf);
            m_unf = unf_set ? 1'b1 : (c ? 1'b0 : m_unf);
        end
    endtask

    task automatic check_all();
        chk("count", count, q.size());
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
        chk("almost_full", almost_full, q.size() >= AF);
        chk("almost_empty", almost_empty, q.size() <= AE);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
`ifdef FIFO_FWFT_EN
        if (q.size() != 0) chk("data_out_head", data_out, q[0]);
`else
        chk("data_out", data_out, m_dout);
`endif
    endtask

    task automatic step(input bit w, input bit r, input logic [DW-1:0] d,
                        input bit c, input bit rs);
        w_en = w; r_en = r; data_in = d; clr_err = c; rst = rs;
        @(posedge clk);
        model_update(w, r, d, c, rs);
        @(negedge clk);
        check_all();
    endtask

    logic [DW-1:0] exp_after_wrap [8];
    int pw, pr;
    bit rw, rr, rc, rrs;

    initial begin
        exp_after_wrap = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd100};
        w_en = 0; r_en = 0; clr_err = 0; rst = 0; data_in = '0;
        @(negedge clk);

        // Reset with a concurrent write request
        step(1, 0, 8'hEE, 0, 1);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_full", full, 0);
        chk("rst_almost_full", almost_full, 0);
`ifndef FIFO_FWFT_EN
        chk("rst_data_out", data_out, 0);
`endif
        step(0, 0, 8'h00, 0, 0);
        chk("rst_no_write", empty, 1);

        // Fill and drain
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 8'(i), 0, 0);
            chk("fill_almost_empty", almost_empty, i <= 1);
            chk("fill_almost_full", almost_full, i >= 6);
            chk("fill_full", full, i == 8);
        end
        for (int i = 1; i <= 8; i++) begin
`ifdef FIFO_FWFT_EN
            chk("drain_data", data_out, i);
            step(0, 1, 8'h00, 0, 0);
`else
            step(0, 1, 8'h00, 0, 0);
            chk("drain_data", data_out, i);
`endif
        end
        chk("drain_empty", empty, 1);

        // Full boundary
        for (int i = 1; i <= 8; i++) step(1, 0, 8'(i), 0, 0);
        step(1, 0, 8'd99, 0, 0);
        chk("full_overflow", overflow, 1);
        chk("full_overflow_count", count, 8);
`ifdef FIFO_FWFT_EN
        chk("full_rw_data", data_out, 1);
        step(1, 1, 8'd100, 0, 0);
`else
        step(1, 1, 8'd100, 0, 0);
        chk("full_rw_data", data_out, 1);
`endif
        chk("full_rw_count", count, 8);
        chk("full_rw_overflow_kept", overflow, 1);
        for (int i = 0; i < 8; i++) begin
`ifdef FIFO_FWFT_EN
            chk("wrap_drain_data", data_out, exp_after_wrap[i]);
            step(0, 1, 8'h00, 0, 0);
`else
            step(0, 1, 8'h00, 0, 0);
            chk("wrap_drain_data", data_out, exp_after_wrap[i]);
`endif
        end

        // Empty boundary
        step(0, 1, 8'h00, 0, 0);
        chk("empty_underflow", underflow, 1);
`ifndef FIFO_FWFT_EN
        chk("empty_read_hold", data_out, 100);
`endif
        step(1, 1, 8'd7, 0, 0);
        chk("empty_rw_count", count, 1);
        step(0, 0, 8'h00, 1, 0);
        chk("clr_overflow", overflow, 0);
        chk("clr_underflow", underflow, 0);
        step(0, 1, 8'h00, 0, 0);
`ifndef FIFO_FWFT_EN
        chk("empty_rw_data", data_out, 7);
`endif
        step(0, 1, 8'h00, 1, 0);
        chk("clr_vs_set_underflow", underflow, 1);
        chk("clr_vs_set_empty", empty, 1);

        // Alternating write/read pairs
        for (int k = 0; k < 20; k++) begin
            step(1, 0, 8'(k + 20), 0, 0);
            chk("alt_count_1", count, 1);
`ifdef FIFO_FWFT_EN
            chk("alt_data", data_out, k + 20);
`endif
            step(0, 1, 8'h00, 0, 0);
            chk("alt_count_0", count, 0);
`ifndef FIFO_FWFT_EN
            chk("alt_data", data_out, k + 20);
`endif
        end

`ifdef FIFO_FWFT_EN
        // Fall-through of the first word
        step(1, 0, 8'h5A, 0, 0);
        chk("fwft_empty", empty, 0);
        chk("fwft_data", data_out, 8'h5A);
        step(0, 1, 8'h00, 0, 0);
        chk("fwft_pop_empty", empty, 1);
`endif

        // Randomised traffic with write-heavy, read-heavy and balanced phases
        for (int i = 0; i < 900; i++) begin
            case ((i / 60) % 3)
                0:       begin pw = 80; pr = 25; end
                1:       begin pw = 25; pr = 80; end
                default: begin pw = 50; pr = 50; end
            endcase
            rw  = ($urandom_range(99) < pw);
            rr  = ($urandom_range(99) < pr);
            rc  = ($urandom_range(99) < 10);
            rrs = ($urandom_range(299) == 0);
            step(rw, rr, 8'($urandom), rc, rrs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_sync_flags.md
Name: fifo_sync_flags

Overview:
Parametrised single-clock synchronous FIFO. It is the next generation of the team's basic FIFO.
- Adds programmable almost-full and almost-empty thresholds.
- Adds an occupancy count output.
- Adds sticky overflow and underflow error flags with a clear input.
- Defines behaviour for simultaneous read and write, including at full and at empty.
- Sits between a producer and a consumer in the same clock domain. It is the DUT behind the team's FIFO bench interface.

Parameters:
- DEPTH, 8: number of entries. Power of 2, minimum 2.
- DATA_WIDTH, 8: word width in bits.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL. Legal range 1..DEPTH.
- AE_LEVEL, 1: almost_empty asserts when count <= AE_LEVEL. Legal range 0..DEPTH-1.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- w_en, input, 1: write request.
- r_en, input, 1: read request.
- data_in, input, DATA_WIDTH: write data.
- data_out, output, DATA_WIDTH: read data.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- almost_full, output, 1: count >= AF_LEVEL.
- almost_empty, output, 1: count <= AE_LEVEL.
- count, output, $clog2(DEPTH+1): current occupancy.
- overflow, output, 1: sticky; a write was rejected.
- underflow, output, 1: sticky; a read was rejected.
- clr_err, input, 1: clears overflow and underflow.

Behaviour:
- Reset (rst=1 at a posedge):
  - wr_ptr, rd_ptr, count, data_out, overflow and underflow go to 0.
  - empty=1, almost_empty=1, full=0.
  - almost_full=0. AF_LEVEL >= 1 guarantees this.
  - Reset takes priority over every other input.
  - Reset mid-stream discards all contents. Memory contents need not be cleared.
- Accept rules, evaluated on registered state at each posedge:
  - rd_ok = r_en && !empty.
  - wr_ok = w_en && (!full || rd_ok). A write into a full FIFO is accepted only when a read is accepted in the same cycle.
- Write: when wr_ok, mem[wr_ptr] <= data_in and wr_ptr increments.
- Read (standard mode): when rd_ok, data_out <= mem[rd_ptr] and rd_ptr increments.
  - Read latency is 1 cycle: data is visible after the posedge that sampled r_en.
  - data_out holds its value on all cycles without rd_ok.
- Pointers: log2(DEPTH) bits wide. They wrap naturally from DEPTH-1 to 0.
- Count update per cycle:
  - +1 when wr_ok only.
  - -1 when rd_ok only.
  - Unchanged when both or neither.
- Flags: full, empty, almost_full and almost_empty are decoded combinationally from the count register. They therefore change in the same cycle as count.
- Empty plus simultaneous w_en and r_en: the write is accepted and the read is rejected, so count becomes 1 and underflow sets.
- Full plus simultaneous w_en and r_en: both are accepted, count stays DEPTH, and there is no overflow.
- Overflow: sets on w_en && full && !rd_ok.
- Underflow: sets on r_en && empty.
- Error clearing:
  - Both flags stay set until clr_err=1 at a posedge.
  - If a new error event and clr_err occur in the same cycle, the set wins.
  - A rejected access never changes the pointers, count or data_out.
- Elaboration checks: DEPTH must be a power of 2, and AF_LEVEL and AE_LEVEL must be in their legal ranges. Violations produce a $fatal.

Optional Feature:
- FIFO_FWFT_EN defined: first-word fall-through mode.
  - data_out continuously presents mem[rd_ptr] whenever empty=0; r_en pops it.
  - The first word written into an empty FIFO appears on data_out in the cycle after the write, the same cycle empty deasserts.
  - data_out is don't-care while empty=1.
  - Accept rules, count, flags and errors are identical to standard mode.
- FIFO_FWFT_EN not defined: standard registered read with 1-cycle latency, as above.

Test Plan (DEPTH=8, DATA_WIDTH=8, AF_LEVEL=6, AE_LEVEL=1):
- Reset: assert rst for 1 cycle with w_en=1 → count=0, empty=1, almost_empty=1, full=0, data_out=0, and no write has occurred.
- Fill and drain: write 1..8 → almost_empty drops at count=2, almost_full rises at count=6, full=1 at count=8. Then read 8 times → data_out is 1..8 in order, each one cycle after its r_en, and empty=1 at the end.
- Full boundary: at full, write 99 alone → overflow=1 with count still 8. Then w_en=r_en=1 with data 100 → count=8, data_out=1, and 100 lands at the wrapped location. Draining returns 2..8 then 100.
- Empty boundary: at empty, r_en alone → underflow=1, data_out unchanged. Then w_en=r_en=1 with data 7 → count=1. Then clr_err → both errors return to 0. Then clr_err together with r_en on an empty FIFO → underflow stays 1.
- Wrap: perform 20 alternating write/read pairs with an incrementing pattern → no data loss or reordering, and count oscillates between 0 and 1.
- FWFT (FIFO_FWFT_EN): write 0x5A into an empty FIFO → the next cycle shows empty=0 and data_out=0x5A with no r_en. Then r_en → empty=1 on the following cycle.
